// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode codes and
// the parameter legality check used at elaboration.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RECOVER
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic bit rx_params_ok(int data_bits, int ovs, int parity, int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (ovs >= 8) && (ovs <= 32) && ((ovs % 2) == 0) &&
           ((parity == PAR_NONE) || (parity == PAR_ODD) || (parity == PAR_EVEN)) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial-side and result-side signals of the configurable UART receiver.
// master = line/tick source and result consumer, slave = the receiver.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 b_tick;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output rx, b_tick,
    input  rx_data, rx_done, parity_err, frame_err, break_det
  );

  modport slave (
    input  rx, b_tick,
    output rx_data, rx_done, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value so idle-high lines come out of reset idle.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable width, parity and stop bits.
// Reports framing, parity and break conditions alongside each received word.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.slave  bus
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TCNT_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(DATA_BITS - 1);

  if (!rx_params_ok(DATA_BITS, OVS, PARITY, STOP_BITS)) begin : g_param_check
    $error("uart_rx_cfg: illegal parameter combination");
  end

  logic rxs;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rxs)
  );

  state_e               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 par_q, par_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 stop_lo_q, stop_lo_d;
  logic                 stop_hi_q, stop_hi_d;
  logic                 rx_done_q, rx_done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;

  logic tick_end;
  logic stop_any_lo;
  logic stop_any_hi;
  logic par_err;
  logic par_low;

  assign tick_end    = (tcnt_q == TCNT_LAST);
  // Stop history including the sample being taken on this tick.
  assign stop_any_lo = stop_lo_q | ~rxs;
  assign stop_any_hi = stop_hi_q | rxs;
  assign par_err     = (PARITY == PAR_NONE) ? 1'b0
                       : ((^shift_q) ^ par_q ^ (PARITY == PAR_ODD));
  assign par_low     = (PARITY == PAR_NONE) ? 1'b1 : ~par_q;

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop_idx_d   = stop_idx_q;
    stop_lo_d    = stop_lo_q;
    stop_hi_d    = stop_hi_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    rx_done_d    = 1'b0;

    if (bus.b_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            tcnt_d  = '0;
          end
        end
        ST_START: begin
          if (tcnt_q == TCNT_HALF) begin
            tcnt_d = '0;
            if (!rxs) begin
              state_d    = ST_DATA;
              bcnt_d     = '0;
              stop_idx_d = 1'b0;
              stop_lo_d  = 1'b0;
              stop_hi_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_end) begin
            tcnt_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == BCNT_LAST) begin
              state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tick_end) begin
            tcnt_d  = '0;
            par_d   = rxs;
            state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_end) begin
            tcnt_d = '0;
            if ((STOP_BITS == 2) && !stop_idx_q) begin
              stop_idx_d = 1'b1;
              stop_lo_d  = stop_any_lo;
              stop_hi_d  = stop_any_hi;
            end else begin
              // Completing at mid-stop leaves room to catch a back-to-back start.
              rx_done_d    = 1'b1;
              rx_data_d    = shift_q;
              parity_err_d = par_err;
              frame_err_d  = stop_any_lo;
              break_det_d  = ~stop_any_hi & ~(|shift_q) & par_low;
              state_d      = stop_any_lo ? ST_RECOVER : ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (rxs) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_idx_q   <= 1'b0;
      stop_lo_q    <= 1'b0;
      stop_hi_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_idx_q   <= stop_idx_d;
      stop_lo_q    <= stop_lo_d;
      stop_hi_q    <= stop_hi_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.break_det  = break_det_q;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the serial front end: oversampled start detection with glitch rejection, configurable data width, parity and stop bits, and framing, parity and break error reporting. It sits between the shared baud-tick generator and the command decoder/FIFO. It replaces the fixed 8N1 receiver in new designs.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
- OVS, 16, b_tick pulses per bit period, even, legal 8..32
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits checked, legal 1 or 2
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial line, asynchronous, idle high
- b_tick  in  1  one-clk enable pulse at OVS × baud rate
- rx_data  out  DATA_BITS  last received word, held until the next rx_done
- rx_done  out  1  one-clk pulse when a frame completes, including errored frames
- parity_err  out  1  parity mismatch on the last frame, valid from rx_done and held
- frame_err  out  1  a stop bit sampled low on the last frame, held
- break_det  out  1  last frame was all-zero, including parity and stop, held

## Operation
- rx passes through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxs.
- FSM advances only on clk edges with b_tick=1. With no b_tick, all state freezes.
- Tick counter tcnt is $clog2(OVS) bits wide. Bit counter bcnt is $clog2(DATA_BITS) bits wide.
- States and transitions:
  - IDLE: on b_tick with rxs=0, go to START and set tcnt=0.
  - START: when tcnt==OVS/2-1, sample. If rxs=0, go to DATA with tcnt=0 and bcnt=0. If rxs=1, the start was a glitch: go to IDLE with no output change. Otherwise tcnt++.
  - DATA: when tcnt==OVS-1, shift rxs into the shift register MSB (right shift) and set tcnt=0. At bcnt==DATA_BITS-1, go to PARITY if PARITY≠0, else STOP. Otherwise bcnt++.
  - PARITY: when tcnt==OVS-1, latch the parity sample and go to STOP.
  - STOP: when tcnt==OVS-1, sample. If STOP_BITS=2 and this is the first stop bit, stay in STOP. After the last stop bit, complete the frame.
  - RECOVER: entered after a completed frame that had frame_err=1. Go to IDLE on the first b_tick with rxs=1.
- Frame completion loads rx_data, parity_err, frame_err and break_det together and pulses rx_done.
  - Next state is IDLE, or RECOVER if any stop sample was 0.
  - Leaving at mid-stop lets a back-to-back start bit be detected.
- parity_err = 1 when the XOR of data bits and the parity bit is 1 (even mode) or 0 (odd mode). It is always 0 when PARITY=0.
- break_det = 1 only when all data, parity and stop samples are 0. It implies frame_err=1.

## Timing
- Reset values: rx_data=0, rx_done=0, parity_err=0, frame_err=0, break_det=0, state=IDLE, counters=0.
- Let b_tick T0 be the one that moves IDLE→START.
- Sample points relative to T0:
  - start: T0 + OVS/2
  - data bit i: T0 + OVS/2 + (i+1)·OVS
  - parity: the next OVS slot after the last data bit
  - stop: the following slots
- rx_done is high for exactly the clk after the b_tick that samples the last stop bit.
- Data and flags change in that same clk and hold until the next completion.
- Synchronizer latency is 2 clk, plus at most one b_tick period of start-detect uncertainty.
- rst mid-frame: immediate return to IDLE, all outputs cleared, no rx_done pulse.
- A low glitch shorter than OVS/2 ticks is rejected with no rx_done and no flag change.
- A line held low indefinitely produces one frame with break_det=1, then stays in RECOVER until the line goes high.

## Structure
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, RECOVER)
  - parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN)
  - the parameter legality check function
- One sub-module: uart_sync2, a 2-flop synchronizer with parametrised reset value, reused by other async inputs.

## Test plan
- Default params, send 0xA5 at 8N1: rx_data=0xA5, exactly one rx_done pulse, all flags 0, rx_done in the clk after T0+OVS/2+9·OVS.
- PARITY=2, send 0x3C with parity 0 → parity_err=0. Then send 0x3C with parity 1 → parity_err=1 and rx_data=0x3C.
- Low pulse of 5 b_ticks on an idle line: no rx_done, FSM back in IDLE, outputs unchanged.
- Line low for 20 bit times, then high, then 0x55:
  - first rx_done gives rx_data=0x00, frame_err=1, break_det=1
  - no further rx_done while the line stays low
  - next rx_done gives 0x55 with flags clear
- DATA_BITS=7, STOP_BITS=2, send 0x41 with the second stop bit low: rx_data=0x41, frame_err=1, break_det=0.
- Assert rst during data bit 4 of 0xF0, then send 0x0F: no rx_done for the aborted frame, outputs 0 during reset, next rx_done gives 0x0F.
